// File: rtl/otter_pkg.sv
// Shared branch-predictor types and helpers for the OTTER pipeline.
// Index/tag extraction is here so the CPU's flush and compare logic slices PCs identically.
package otter_pkg;

    localparam int BP_MAX_XLEN  = 64;
    localparam int BP_DEF_XLEN  = 32;
    localparam int BP_DEF_TAG_W = 8;
    localparam int BP_DEF_CNT_W = 2;

    // Full entry view for the default geometry, as seen by debug/compare logic.
    typedef struct packed {
        logic                    valid;
        logic                    jump;
        logic [BP_DEF_TAG_W-1:0] tag;
        logic [BP_DEF_XLEN-1:0]  target;
        logic [BP_DEF_CNT_W-1:0] cnt;
    } bp_entry_t;

    function automatic int unsigned BP_CNT_WEAK_T(input int cnt_w);
        return 32'd1 << (cnt_w - 1);
    endfunction

    function automatic int unsigned BP_CNT_WEAK_NT(input int cnt_w);
        return BP_CNT_WEAK_T(cnt_w) - 32'd1;
    endfunction

    function automatic int unsigned bp_index(input logic [BP_MAX_XLEN-1:0] pc, input int idx_w);
        return 32'((pc >> 2) & ((64'd1 << idx_w) - 64'd1));
    endfunction

    function automatic int unsigned bp_tag(input logic [BP_MAX_XLEN-1:0] pc, input int idx_w,
                                           input int tag_w);
        return 32'((pc >> (idx_w + 2)) & ((64'd1 << tag_w) - 64'd1));
    endfunction

    function automatic logic [31:0] bp_sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/otter_sat_counter.sv
// Saturating up/down counter with parallel load; one per predictor entry.
module otter_sat_counter
#(
    parameter int               CNT_W = 2,
    parameter logic [CNT_W-1:0] INIT  = '0
)
(
    input  logic             CLK,
    input  logic             RESET,
    input  logic             inc,
    input  logic             dec,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt <= INIT;
        end else if (load) begin
            cnt <= load_val;
        end else if (inc) begin
            if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
        end else if (dec) begin
            if (cnt != '0) cnt <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/otter_branch_predictor.sv
// Direct-mapped BTB with per-entry saturating direction counters; 0-cycle lookup, trained from execute.
// Optional statistics counters are built when OTTER_BP_STATS_EN is defined.
module otter_branch_predictor
    import otter_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16,
    parameter int TAG_W   = 8,
    parameter int CNT_W   = 2
)
(
    input  logic            CLK,
    input  logic            RESET,
    input  logic [XLEN-1:0] IF_PC,
    output logic            PRED_TAKEN,
    output logic [XLEN-1:0] PRED_TARGET,
    input  logic            UPD_VALID,
    input  logic [XLEN-1:0] UPD_PC,
    input  logic            UPD_JUMP,
    input  logic            UPD_TAKEN,
    input  logic [XLEN-1:0] UPD_TARGET,
    input  logic            UPD_MISPRED,
    input  logic            FLUSH
`ifdef OTTER_BP_STATS_EN
    ,
    output logic [31:0]     STAT_UPDATES,
    output logic [31:0]     STAT_MISPRED,
    output logic [31:0]     STAT_HITS
`endif
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [CNT_W-1:0] CNT_WEAK_T  = CNT_W'(BP_CNT_WEAK_T(CNT_W));
    localparam logic [CNT_W-1:0] CNT_WEAK_NT = CNT_W'(BP_CNT_WEAK_NT(CNT_W));

    typedef struct packed {
        logic             valid;
        logic             jump;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  target;
    } slot_t;

    slot_t            table_q [ENTRIES];
    logic [CNT_W-1:0] cnt_q   [ENTRIES];

    logic [IDX_W-1:0] lu_idx;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] lu_tag;
    logic [TAG_W-1:0] upd_tag;
    slot_t            lu_slot;
    logic [CNT_W-1:0] lu_cnt;
    logic             lu_hit;
    logic             upd_hit;
    logic             upd_taken;
    logic             upd_en;
    logic             write_slot;
    logic             cnt_inc;
    logic             cnt_dec;
    logic             cnt_load;

    assign lu_idx  = IDX_W'(bp_index(BP_MAX_XLEN'(IF_PC), IDX_W));
    assign lu_tag  = TAG_W'(bp_tag(BP_MAX_XLEN'(IF_PC), IDX_W, TAG_W));
    assign upd_idx = IDX_W'(bp_index(BP_MAX_XLEN'(UPD_PC), IDX_W));
    assign upd_tag = TAG_W'(bp_tag(BP_MAX_XLEN'(UPD_PC), IDX_W, TAG_W));

    // Lookup reads the registered table, so a same-cycle update is not visible until the next cycle.
    assign lu_slot     = table_q[lu_idx];
    assign lu_cnt      = cnt_q[lu_idx];
    assign lu_hit      = lu_slot.valid && (lu_slot.tag == lu_tag);
    assign PRED_TAKEN  = lu_hit && (lu_slot.jump || (lu_cnt >= CNT_WEAK_T));
    assign PRED_TARGET = lu_hit ? lu_slot.target : IF_PC + XLEN'(4);

    assign upd_hit    = table_q[upd_idx].valid && (table_q[upd_idx].tag == upd_tag);
    assign upd_taken  = UPD_JUMP || UPD_TAKEN;
    assign upd_en     = UPD_VALID && !FLUSH;
    assign write_slot = upd_en && upd_taken;
    assign cnt_inc    = upd_en && upd_hit && !UPD_JUMP && UPD_TAKEN;
    assign cnt_dec    = upd_en && upd_hit && !UPD_JUMP && !UPD_TAKEN;
    assign cnt_load   = upd_en && !upd_hit && upd_taken;

    // A taken outcome rewrites the slot whether it hit or allocated; on a hit valid/tag are unchanged.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < ENTRIES; i++) table_q[i] <= '0;
        end else if (FLUSH) begin
            for (int i = 0; i < ENTRIES; i++) table_q[i].valid <= 1'b0;
        end else if (write_slot) begin
            table_q[upd_idx] <= '{valid: 1'b1, jump: UPD_JUMP, tag: upd_tag, target: UPD_TARGET};
        end
    end

    for (genvar g = 0; g < ENTRIES; g++) begin : g_cnt
        logic sel;
        assign sel = (upd_idx == IDX_W'(g));

        otter_sat_counter #(
            .CNT_W (CNT_W),
            .INIT  (CNT_WEAK_NT)
        ) u_cnt (
            .CLK      (CLK),
            .RESET    (RESET),
            .inc      (cnt_inc && sel),
            .dec      (cnt_dec && sel),
            .load     (cnt_load && sel),
            .load_val (CNT_WEAK_T),
            .cnt      (cnt_q[g])
        );
    end

`ifdef OTTER_BP_STATS_EN
    // Updates dropped by a concurrent flush are not counted; flush leaves the totals alone.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            STAT_UPDATES <= '0;
            STAT_MISPRED <= '0;
            STAT_HITS    <= '0;
        end else begin
            if (upd_en)                STAT_UPDATES <= bp_sat_inc(STAT_UPDATES);
            if (upd_en && UPD_MISPRED) STAT_MISPRED <= bp_sat_inc(STAT_MISPRED);
            if (PRED_TAKEN)            STAT_HITS    <= bp_sat_inc(STAT_HITS);
        end
    end
`else
    logic unused_mispred;
    assign unused_mispred = UPD_MISPRED;
`endif

endmodule

// File: tb/tb_otter_branch_predictor.sv
// Self-checking bench for otter_branch_predictor: directed vector table, hand sequences and a randomized run.
module tb_otter_branch_predictor;

    localparam int NUM_IDX  = 16;
    localparam int NUM_TAGS = 256;
    localparam int CNT_MAX  = 3;
    localparam int CNT_HALF = 2;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] IF_PC;
    logic        PRED_TAKEN;
    logic [31:0] PRED_TARGET;
    logic        UPD_VALID;
    logic [31:0] UPD_PC;
    logic        UPD_JUMP;
    logic        UPD_TAKEN;
    logic [31:0] UPD_TARGET;
    logic        UPD_MISPRED;
    logic        FLUSH;
`ifdef OTTER_BP_STATS_EN
    logic [31:0] STAT_UPDATES;
    logic [31:0] STAT_MISPRED;
    logic [31:0] STAT_HITS;
`endif

    always #5 CLK = ~CLK;

    otter_branch_predictor dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .IF_PC       (IF_PC),
        .PRED_TAKEN  (PRED_TAKEN),
        .PRED_TARGET (PRED_TARGET),
        .UPD_VALID   (UPD_VALID),
        .UPD_PC      (UPD_PC),
        .UPD_JUMP    (UPD_JUMP),
        .UPD_TAKEN   (UPD_TAKEN),
        .UPD_TARGET  (UPD_TARGET),
        .UPD_MISPRED (UPD_MISPRED),
        .FLUSH       (FLUSH)
`ifdef OTTER_BP_STATS_EN
        ,
        .STAT_UPDATES (STAT_UPDATES),
        .STAT_MISPRED (STAT_MISPRED),
        .STAT_HITS    (STAT_HITS)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model: one record per index, counters kept as plain integers.
    bit          m_valid [NUM_IDX];
    bit          m_jump  [NUM_IDX];
    int unsigned m_tag   [NUM_IDX];
    logic [31:0] m_tgt   [NUM_IDX];
    int          m_cnt   [NUM_IDX];
    longint      m_upd;
    longint      m_mis;
    longint      m_hits;

    typedef struct {
        logic        rst;
        logic        flush;
        logic        uv;
        logic [31:0] upc;
        logic        uj;
        logic        ut;
        logic [31:0] utgt;
        logic [31:0] ifpc;
        logic        exp_taken;
        logic [31:0] exp_target;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic flush, input logic uv,
                                input logic [31:0] upc, input logic uj, input logic ut,
                                input logic [31:0] utgt, input logic [31:0] ifpc,
                                input logic et, input logic [31:0] etgt);
        vec_t v;
        v.rst = rst; v.flush = flush; v.uv = uv; v.upc = upc; v.uj = uj; v.ut = ut;
        v.utgt = utgt; v.ifpc = ifpc; v.exp_taken = et; v.exp_target = etgt;
        return v;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NUM_IDX; i++) begin
            m_valid[i] = 0; m_jump[i] = 0; m_tag[i] = 0; m_tgt[i] = '0; m_cnt[i] = CNT_HALF - 1;
        end
        m_upd = 0; m_mis = 0; m_hits = 0;
    endfunction

    function automatic void model_predict(input logic [31:0] pc, output logic taken,
                                          output logic [31:0] target);
        int unsigned idx = (pc >> 2) % NUM_IDX;
        int unsigned tag = (pc >> 6) % NUM_TAGS;
        bit hit = m_valid[idx] && (m_tag[idx] == tag);
        taken  = hit && (m_jump[idx] || (m_cnt[idx] >= CNT_HALF));
        target = hit ? m_tgt[idx] : pc + 32'd4;
    endfunction

    function automatic void model_update(input logic rst, input logic flush, input logic uv,
                                         input logic [31:0] upc, input logic uj, input logic ut,
                                         input logic [31:0] utgt, input logic umis,
                                         input logic pred_taken);
        int unsigned idx = (upc >> 2) % NUM_IDX;
        int unsigned tag = (upc >> 6) % NUM_TAGS;
        bit hit = m_valid[idx] && (m_tag[idx] == tag);
        bit taken = uj || ut;
        if (rst) begin
            model_reset();
            return;
        end
        if (pred_taken) m_hits++;
        if (flush) begin
            for (int i = 0; i < NUM_IDX; i++) m_valid[i] = 0;
            return;
        end
        if (!uv) return;
        m_upd++;
        if (umis) m_mis++;
        if (hit) begin
            if (!uj) m_cnt[idx] = ut ? ((m_cnt[idx] < CNT_MAX) ? m_cnt[idx] + 1 : CNT_MAX)
                                     : ((m_cnt[idx] > 0) ? m_cnt[idx] - 1 : 0);
            if (taken) begin
                m_tgt[idx] = utgt; m_jump[idx] = uj;
            end
        end else if (taken) begin
            m_valid[idx] = 1; m_tag[idx] = tag; m_tgt[idx] = utgt; m_jump[idx] = uj;
            m_cnt[idx] = CNT_HALF;
        end
    endfunction

    task automatic applyStimulus(input logic rst, input logic flush, input logic uv,
                                 input logic [31:0] upc, input logic uj, input logic ut,
                                 input logic [31:0] utgt, input logic umis,
                                 input logic [31:0] ifpc);
        RESET = rst; FLUSH = flush; UPD_VALID = uv; UPD_PC = upc; UPD_JUMP = uj;
        UPD_TAKEN = ut; UPD_TARGET = utgt; UPD_MISPRED = umis; IF_PC = ifpc;
    endtask

    task automatic checkOutput(input string name, input logic exp_taken, input logic [31:0] exp_target);
        checks++;
        if (PRED_TAKEN !== exp_taken) begin
            errors++;
            $display("[TB] FAIL %s PRED_TAKEN: got %0b expected %0b", name, PRED_TAKEN, exp_taken);
        end
        checks++;
        if (PRED_TARGET !== exp_target) begin
            errors++;
            $display("[TB] FAIL %s PRED_TARGET: got %h expected %h", name, PRED_TARGET, exp_target);
        end
    endtask

    task automatic check_stat(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] pc;
        pc = (($urandom % 4) << 6) | (($urandom % 16) << 2) | ($urandom % 4);
        if ($urandom % 8 == 0) pc = pc | 32'hFFFF_FF00;
        return pc;
    endfunction

    initial begin
        logic        exp_t;
        logic [31:0] exp_tgt;
        vec_t        v;

        $display("[TB] starting otter_branch_predictor bench");
        applyStimulus(1, 0, 0, '0, 0, 0, '0, 0, 32'h100);
        @(posedge CLK);
        @(posedge CLK);
        #1;
        model_reset();

        // Directed vectors: inputs held for one cycle, outputs checked before the edge.
        vecs.push_back(mk(1, 0, 0, 32'h000, 0, 0, 32'h000, 32'h100, 0, 32'h104));
        vecs.push_back(mk(0, 0, 1, 32'h100, 0, 1, 32'h080, 32'h100, 0, 32'h104));
        vecs.push_back(mk(0, 0, 0, 32'h000, 0, 0, 32'h000, 32'h100, 1, 32'h080));
        vecs.push_back(mk(0, 0, 1, 32'h100, 0, 0, 32'h080, 32'h100, 1, 32'h080));
        vecs.push_back(mk(0, 0, 1, 32'h100, 0, 0, 32'h080, 32'h100, 0, 32'h080));
        vecs.push_back(mk(0, 0, 1, 32'h100, 0, 1, 32'h080, 32'h100, 0, 32'h080));
        vecs.push_back(mk(0, 0, 1, 32'h100, 0, 1, 32'h080, 32'h100, 0, 32'h080));
        vecs.push_back(mk(0, 0, 1, 32'h100, 0, 1, 32'h080, 32'h100, 1, 32'h080));
        vecs.push_back(mk(0, 0, 1, 32'h100, 0, 1, 32'h080, 32'h100, 1, 32'h080));
        vecs.push_back(mk(0, 0, 1, 32'h100, 0, 0, 32'h080, 32'h100, 1, 32'h080));
        vecs.push_back(mk(0, 0, 0, 32'h000, 0, 0, 32'h000, 32'h100, 1, 32'h080));
        vecs.push_back(mk(0, 0, 1, 32'h140, 0, 1, 32'h300, 32'h100, 1, 32'h080));
        vecs.push_back(mk(0, 0, 0, 32'h000, 0, 0, 32'h000, 32'h100, 0, 32'h104));
        vecs.push_back(mk(0, 0, 0, 32'h000, 0, 0, 32'h000, 32'h140, 1, 32'h300));
        vecs.push_back(mk(0, 0, 1, 32'h200, 1, 1, 32'h400, 32'h200, 0, 32'h204));
        vecs.push_back(mk(0, 0, 0, 32'h000, 0, 0, 32'h000, 32'h200, 1, 32'h400));
        vecs.push_back(mk(0, 0, 0, 32'h000, 0, 0, 32'h000, 32'h140, 0, 32'h144));
        vecs.push_back(mk(0, 0, 1, 32'h204, 1, 0, 32'h500, 32'h204, 0, 32'h208));
        vecs.push_back(mk(0, 0, 0, 32'h000, 0, 0, 32'h000, 32'h204, 1, 32'h500));
        vecs.push_back(mk(0, 1, 1, 32'h300, 0, 1, 32'h010, 32'h200, 1, 32'h400));
        vecs.push_back(mk(0, 0, 0, 32'h000, 0, 0, 32'h000, 32'h200, 0, 32'h204));
        vecs.push_back(mk(0, 0, 0, 32'h000, 0, 0, 32'h000, 32'h300, 0, 32'h304));
        vecs.push_back(mk(0, 0, 0, 32'h000, 0, 0, 32'h000, 32'h204, 0, 32'h208));
        vecs.push_back(mk(0, 0, 0, 32'h000, 0, 0, 32'h000, 32'hFFFF_FFFC, 0, 32'h0000_0000));
        vecs.push_back(mk(0, 0, 1, 32'h100, 0, 1, 32'h084, 32'h100, 0, 32'h104));
        vecs.push_back(mk(0, 0, 0, 32'h000, 0, 0, 32'h000, 32'h100, 1, 32'h084));
        vecs.push_back(mk(1, 1, 1, 32'h100, 0, 1, 32'h088, 32'h100, 1, 32'h084));
        vecs.push_back(mk(0, 0, 0, 32'h000, 0, 0, 32'h000, 32'h100, 0, 32'h104));

        foreach (vecs[k]) begin
            v = vecs[k];
            applyStimulus(v.rst, v.flush, v.uv, v.upc, v.uj, v.ut, v.utgt, 0, v.ifpc);
            #1;
            checkOutput($sformatf("vec%0d", k), v.exp_taken, v.exp_target);
            model_predict(v.ifpc, exp_t, exp_tgt);
            @(posedge CLK);
            model_update(v.rst, v.flush, v.uv, v.upc, v.uj, v.ut, v.utgt, 0, exp_t);
            #1;
        end

        // Randomized training against the reference model.
        for (int n = 0; n < 600; n++) begin
            logic        r_rst, r_fl, r_uv, r_uj, r_ut, r_mis;
            logic [31:0] r_upc, r_tgt, r_if;
            r_rst = ($urandom % 64 == 0);
            r_fl  = ($urandom % 32 == 0);
            r_uv  = ($urandom % 2 == 0);
            r_uj  = ($urandom % 4 == 0);
            r_ut  = ($urandom % 3 != 0);
            r_mis = ($urandom % 3 == 0);
            r_upc = rand_pc();
            r_tgt = $urandom & 32'hFFFF_FFFC;
            r_if  = ($urandom % 4 == 0) ? r_upc : rand_pc();
            applyStimulus(r_rst, r_fl, r_uv, r_upc, r_uj, r_ut, r_tgt, r_mis, r_if);
            #1;
            model_predict(r_if, exp_t, exp_tgt);
            checkOutput($sformatf("rand%0d", n), exp_t, exp_tgt);
`ifdef OTTER_BP_STATS_EN
            check_stat($sformatf("rand%0d STAT_UPDATES", n), STAT_UPDATES, 32'(m_upd));
            check_stat($sformatf("rand%0d STAT_MISPRED", n), STAT_MISPRED, 32'(m_mis));
            check_stat($sformatf("rand%0d STAT_HITS", n), STAT_HITS, 32'(m_hits));
`endif
            @(posedge CLK);
            model_update(r_rst, r_fl, r_uv, r_upc, r_uj, r_ut, r_tgt, r_mis, exp_t);
            #1;
        end

`ifdef OTTER_BP_STATS_EN
        // Statistics sequence: five updates with two mispredicts, one taken hit, then flush and reset.
        applyStimulus(1, 0, 0, '0, 0, 0, '0, 0, 32'h2000);
        @(posedge CLK); #1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 1, 32'h1000, 0, 1, 32'h40, (i < 2), 32'h2000);
            @(posedge CLK); #1;
        end
        applyStimulus(0, 0, 0, '0, 0, 0, '0, 0, 32'h1000);
        #1;
        check_stat("stats STAT_UPDATES after 5", STAT_UPDATES, 32'd5);
        check_stat("stats STAT_MISPRED after 5", STAT_MISPRED, 32'd2);
        check_stat("stats STAT_HITS before hit", STAT_HITS, 32'd0);
        @(posedge CLK); #1;
        applyStimulus(0, 1, 1, 32'h1000, 0, 1, 32'h40, 1, 32'h2000);
        #1;
        check_stat("stats STAT_HITS after hit", STAT_HITS, 32'd1);
        @(posedge CLK); #1;
        applyStimulus(0, 0, 0, '0, 0, 0, '0, 0, 32'h2000);
        #1;
        check_stat("stats STAT_UPDATES after flush", STAT_UPDATES, 32'd5);
        check_stat("stats STAT_MISPRED after flush", STAT_MISPRED, 32'd2);
        check_stat("stats STAT_HITS after flush", STAT_HITS, 32'd1);
        @(posedge CLK); #1;
        applyStimulus(1, 0, 0, '0, 0, 0, '0, 0, 32'h2000);
        @(posedge CLK); #1;
        applyStimulus(0, 0, 0, '0, 0, 0, '0, 0, 32'h2000);
        #1;
        check_stat("stats STAT_UPDATES after reset", STAT_UPDATES, 32'd0);
        check_stat("stats STAT_MISPRED after reset", STAT_MISPRED, 32'd0);
        check_stat("stats STAT_HITS after reset", STAT_HITS, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
